// File: rtl/duration.sv
// Note-duration timer: a prescaler turns clk into ticks, a tick counter
// counts dur ticks and pulses done once at the end of every period.
module duration #(
    parameter int unsigned SPEED_W = 128,
    parameter int unsigned DUR_W   = 8
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic [DUR_W-1:0]   dur,
    input  logic [SPEED_W-1:0] clockSpeed,
    output logic               done
);

    logic [SPEED_W-1:0] r_p;
    logic [DUR_W-1:0]   r_t;
    logic               r_done;

    logic [SPEED_W:0]   w_cs_eff;
    logic [DUR_W:0]     w_d_eff;
    logic [SPEED_W:0]   w_p_inc;
    logic [DUR_W:0]     w_t_inc;
    logic               w_tick;
    logic               w_wrap;
    logic [SPEED_W-1:0] w_p_nxt;
    logic [DUR_W-1:0]   w_t_nxt;
    logic               w_done_nxt;

    // Zero bounds behave like one; compares are one bit wider so the
    // largest bound never wraps the incremented counter.
    always_comb begin
        w_cs_eff = (clockSpeed == '0) ? (SPEED_W+1)'(1) : {1'b0, clockSpeed};
        w_d_eff  = (dur == '0)        ? (DUR_W+1)'(1)   : {1'b0, dur};
        w_p_inc  = {1'b0, r_p} + (SPEED_W+1)'(1);
        w_t_inc  = {1'b0, r_t} + (DUR_W+1)'(1);
        w_tick   = (w_p_inc >= w_cs_eff);
        w_wrap   = (w_t_inc >= w_d_eff);
    end

    // Next-state: >= lets a lowered bound end the period at once.
    always_comb begin
        w_p_nxt    = w_p_inc[SPEED_W-1:0];
        w_t_nxt    = r_t;
        w_done_nxt = 1'b0;
        if (w_tick) begin
            w_p_nxt = '0;
            if (w_wrap) begin
                w_t_nxt    = '0;
                w_done_nxt = 1'b1;
            end else begin
                w_t_nxt = w_t_inc[DUR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_p    <= '0;
            r_t    <= '0;
            r_done <= 1'b0;
        end else begin
            r_p    <= w_p_nxt;
            r_t    <= w_t_nxt;
            r_done <= w_done_nxt;
        end
    end

    assign done = r_done;

endmodule

// File: tb/tb_duration.sv
// Bench for duration: a bench-side timing model checked every cycle, plus
// literal edge-number expectations for each directed scenario.
module tb_duration;

    localparam int unsigned SPEED_W = 128;
    localparam int unsigned DUR_W   = 8;

    logic               clk = 1'b0;
    logic               nreset = 1'b0;
    logic [DUR_W-1:0]   dur = '0;
    logic [SPEED_W-1:0] clockSpeed = '0;
    logic               done;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    duration #(.SPEED_W(SPEED_W), .DUR_W(DUR_W)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .dur        (dur),
        .clockSpeed (clockSpeed),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Model: clk cycles into the current tick, ticks into the current period.
    logic [SPEED_W:0] m_p;
    int               m_t;
    logic             m_done;

    function automatic logic [SPEED_W:0] eff_cs(input logic [SPEED_W-1:0] c);
        logic [SPEED_W:0] r;
        r = {1'b0, c};
        if (c == '0) r = (SPEED_W+1)'(1);
        return r;
    endfunction

    function automatic int eff_d(input logic [DUR_W-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_p    <= '0;
            m_t    <= 0;
            m_done <= 1'b0;
        end else if (m_p + 1 >= eff_cs(clockSpeed)) begin
            m_p <= '0;
            if (m_t + 1 >= eff_d(dur)) begin
                m_t    <= 0;
                m_done <= 1'b1;
            end else begin
                m_t    <= m_t + 1;
                m_done <= 1'b0;
            end
        end else begin
            m_p    <= m_p + 1;
            m_done <= 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        checks++;
        if (done !== m_done) begin
            errors++;
            $display("FAIL model t=%0t edge=%0d done=%b expected=%b", $time, edge_n, done, m_done);
        end
    end

    task automatic chk(input string name, input logic exp);
        checks++;
        if (done !== exp) begin
            errors++;
            $display("FAIL %s t=%0t edge=%0d done=%b expected=%b", name, $time, edge_n, done, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        nreset = 1'b0;
        repeat (n) @(negedge clk);
        nreset = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        // Basic 10x10 period
        dur = 8'd10; clockSpeed = 128'd10;
        do_reset(3);
        chk("reset_state", 1'b0);
        run_to(1);   chk("p100_e1", 1'b0);
        run_to(99);  chk("p100_e99", 1'b0);
        run_to(100); chk("p100_e100", 1'b1);
        run_to(101); chk("p100_e101", 1'b0);
        run_to(199); chk("p100_e199", 1'b0);
        run_to(200); chk("p100_e200", 1'b1);
        run_to(300); chk("p100_e300", 1'b1);

        // Unit bounds: continuous done, then async reset clears it mid-cycle
        dur = 8'd1; clockSpeed = 128'd1;
        do_reset(2);
        for (int i = 1; i <= 5; i++) begin
            run_to(i); chk("ones", 1'b1);
        end
        @(posedge clk); #3;
        nreset = 1'b0;
        #1 chk("async_rst", 1'b0);
        dur = 8'd0; clockSpeed = 128'd0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        edge_n = 0;
        for (int i = 1; i <= 5; i++) begin
            run_to(i); chk("zeros", 1'b1);
        end

        // Full 255-tick period
        dur = 8'd255; clockSpeed = 128'd3;
        do_reset(2);
        run_to(764);  chk("d255_e764", 1'b0);
        run_to(765);  chk("d255_e765", 1'b1);
        run_to(1529); chk("d255_e1529", 1'b0);
        run_to(1530); chk("d255_e1530", 1'b1);

        // Reset mid-period at cycle 57, then a full period after release
        dur = 8'd10; clockSpeed = 128'd10;
        do_reset(2);
        run_to(57);
        #2 nreset = 1'b0;
        #1 chk("midrst_low", 1'b0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        edge_n = 0;
        run_to(99);  chk("midrst_e99", 1'b0);
        run_to(100); chk("midrst_e100", 1'b1);

        // Lower dur to 3 with t=5: period ends at edge 60, then every 30
        do_reset(2);
        run_to(55);
        @(negedge clk); dur = 8'd3;
        run_to(59); chk("lowd_e59", 1'b0);
        run_to(60); chk("lowd_e60", 1'b1);
        run_to(89); chk("lowd_e89", 1'b0);
        run_to(90); chk("lowd_e90", 1'b1);

        // Raise dur to 20 at t=5: current period stretches to edge 200
        dur = 8'd10;
        do_reset(2);
        run_to(50);
        @(negedge clk); dur = 8'd20;
        run_to(100); chk("raised_e100", 1'b0);
        run_to(199); chk("raised_e199", 1'b0);
        run_to(200); chk("raised_e200", 1'b1);

        // Lower clockSpeed below p: tick forced, then 5-cycle ticks
        dur = 8'd10; clockSpeed = 128'd10;
        do_reset(2);
        run_to(7);
        @(negedge clk); clockSpeed = 128'd5;
        run_to(52); chk("lowcs_e52", 1'b0);
        run_to(53); chk("lowcs_e53", 1'b1);

        // Maximum clockSpeed never ticks within the run
        dur = 8'd1; clockSpeed = '1;
        do_reset(2);
        run_to(1000); chk("maxcs_e1000", 1'b0);

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
